// File: rtl/write_address.sv
// Write-side pointer and status generator for the synchronous FIFO.
// Owns the write pointer and derives fill level, full/almost-full, write ack and sticky overflow.
module write_address #(
    parameter int MEMORY_DEPTH      = 8,
    parameter int FIFO_ADDRESS_SIZE = 3,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_req,
    input  logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
    input  logic                         ovf_clr,
    output logic                         cw_en,
    output logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
    output logic [FIFO_ADDRESS_SIZE-1:0] w_addr,
    output logic [FIFO_ADDRESS_SIZE:0]   fill_level,
    output logic                         full,
    output logic                         almost_full,
    output logic                         wr_ack,
    output logic                         overflow
);

    localparam int PTR_W = FIFO_ADDRESS_SIZE + 1;
    localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(MEMORY_DEPTH);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(ALMOST_FULL_LEVEL);

    logic wr_reject;

    // Pointers carry a lap bit, so modular subtraction gives 0..MEMORY_DEPTH unambiguously.
    assign fill_level  = w_ptr - r_ptr;
    assign full        = (fill_level == DEPTH_LVL);
    assign almost_full = (fill_level >= AF_LVL);
    assign cw_en       = wr_req & ~full;
    assign wr_reject   = wr_req & full;
    assign w_addr      = w_ptr[FIFO_ADDRESS_SIZE-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            wr_ack   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (cw_en)
                w_ptr <= w_ptr + 1'b1;
            wr_ack <= cw_en;
            // A rejected write in the same cycle as a clear keeps the flag set.
            if (wr_reject)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: doc/write_address.md
# write_address

Write-side pointer and status generator for the synchronous FIFO; the counterpart of the read-address counter. It owns the write pointer, qualifies write requests into a memory write enable, and derives fill level, full/almost-full flags, write acknowledge and a sticky overflow flag by comparing its pointer with the read pointer. It sits between the FIFO's producer interface and the memory write port, sharing the FIFO clock with the read side.

## Interface
- MEMORY_DEPTH, 8, number of FIFO entries; must equal 2**FIFO_ADDRESS_SIZE
- FIFO_ADDRESS_SIZE, 3, memory address width; pointers are FIFO_ADDRESS_SIZE+1 bits (MSB = lap bit)
- ALMOST_FULL_LEVEL, 6, fill level at or above which almost_full asserts; range 1..MEMORY_DEPTH
- clk  input  1  FIFO clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_req  input  1  producer write request, sampled each cycle
- r_ptr  input  FIFO_ADDRESS_SIZE+1  read pointer from the read-address counter, same clock domain
- ovf_clr  input  1  synchronous clear of overflow
- cw_en  output  1  memory write enable / write-pointer increment enable (combinational)
- w_ptr  output  FIFO_ADDRESS_SIZE+1  registered write pointer
- w_addr  output  FIFO_ADDRESS_SIZE  memory write address = w_ptr[FIFO_ADDRESS_SIZE-1:0]
- fill_level  output  FIFO_ADDRESS_SIZE+1  entries currently held, 0..MEMORY_DEPTH
- full  output  1  fill_level == MEMORY_DEPTH
- almost_full  output  1  fill_level >= ALMOST_FULL_LEVEL
- wr_ack  output  1  registered; pulses the cycle after an accepted write
- overflow  output  1  sticky; set by a write request while full

## Operation
- fill_level = (w_ptr - r_ptr) modulo 2**(FIFO_ADDRESS_SIZE+1); combinational from current w_ptr and r_ptr.
- full, almost_full: combinational decode of fill_level; no lookahead.
- cw_en = wr_req & ~full. Write data is stored at w_addr in the same cycle cw_en is high.
- w_ptr increments by 1 on each clock with cw_en = 1; natural binary wrap from all-ones to 0 (lap bit toggles each pass through the memory).
- wr_ack <= cw_en every cycle.
- overflow: set when wr_req & full; cleared when ovf_clr & ~(wr_req & full); set wins over clear in the same cycle. Rejected write does not move w_ptr or any memory contents.
- Empty condition (w_ptr == r_ptr) is owned by the read side; this block reports fill_level 0 only.

## Timing
- Reset (rst_n low, asynchronous, any cycle): w_ptr = 0, wr_ack = 0, overflow = 0. With r_ptr also reset to 0: fill_level = 0, full = 0, almost_full = 0, cw_en = wr_req.
- Reset mid-operation: pointer and flags clear immediately, independent of clk; in-flight wr_ack is dropped.
- Accepted write at edge N: w_ptr, fill_level updated after edge N; wr_ack high in cycle N+1 only.
- Write at fill_level = MEMORY_DEPTH-1: accepted; full asserts the following cycle.
- Read and write in the same cycle when not full: w_ptr and r_ptr both advance; fill_level unchanged.
- Write request while full with a concurrent read: rejected (full is current-cycle); overflow sets; fill_level drops by 1 next cycle.
- Back-to-back writes: one accepted per cycle, sustained rate 1 write/clock until full.

## Test plan
- Reset: drive rst_n low mid-burst (w_ptr = 5) -> w_ptr = 0, wr_ack = 0, overflow = 0 without a clock edge; fill_level = 0 with r_ptr = 0.
- Fill: r_ptr = 0, 8 consecutive wr_req -> w_addr 0..7, cw_en high 8 cycles, wr_ack high 8 cycles delayed by 1, almost_full from fill_level 6, full after 8th write, w_ptr = 8 (4'b1000).
- Overflow: full, wr_req held 2 cycles -> cw_en = 0, w_ptr stays 8, overflow = 1; ovf_clr with wr_req low -> overflow = 0 next cycle; ovf_clr with wr_req high while full -> overflow stays 1.
- Wrap: r_ptr = 14, w_ptr = 14, 4 writes -> w_ptr sequence 15, 0, 1, 2; w_addr 6, 7, 0, 1; fill_level 4 at end, full = 0.
- Concurrent: fill_level = 7, simultaneous write and r_ptr increment -> fill_level stays 7, full never asserts; at fill_level = 8 write plus read -> write rejected, fill_level = 7, overflow = 1.
- Idle: wr_req = 0 for 20 cycles at fill_level 3 -> w_ptr, flags, wr_ack unchanged (wr_ack = 0).
